// File: rtl/gbe_pkg.sv
// rtl/gbe_pkg.sv - shared constants and state type for the 10GbE transmit path
package gbe_pkg;

   // Words per frame, including the 64-bit payload-counter header; shared with the packetizer
   localparam int FRAME_WORDS_DEF = 1025;

   // Width of one stream word
   localparam int WORD_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } gate_state_t;

endpackage

// File: rtl/gbe_stat_counter.sv
// rtl/gbe_stat_counter.sv - wrapping status counter with priority clear
module gbe_stat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   // Clear beats a same-cycle increment; increment wraps modulo 2^W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/gbe_tx_gate.sv
// rtl/gbe_tx_gate.sv - whole-frame admission gate between packetizer and 10GbE core
module gbe_tx_gate
   import gbe_pkg::*;
#(
   parameter int FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int CNT_W       = 32,
   parameter int ERR_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   input  logic              tx_eof,
   input  logic              enable,
   input  logic              clear,
   input  logic              gbe_link_up,
   input  logic              gbe_tx_afull,
   input  logic              gbe_tx_overflow,
   output logic [WORD_W-1:0] gbe_tx_data,
   output logic              gbe_tx_valid,
   output logic              gbe_tx_eof,
   output logic [CNT_W-1:0]  pkt_sent,
   output logic [CNT_W-1:0]  pkt_dropped,
   output logic [ERR_W-1:0]  len_err,
   output logic              overflow_sticky
);

   localparam int            CW      = $clog2(FRAME_WORDS + 1);
   localparam logic [CW-1:0] LP_LAST = CW'(FRAME_WORDS);
   localparam logic [CW-1:0] LP_ONE  = CW'(1);

   gate_state_t       r_state;
   gate_state_t       w_next;
   logic [CW-1:0]     r_wcnt;
   logic [CW-1:0]     w_word_num;
   logic              w_acc;
   logic              w_admit;
   logic              w_last;
   logic              w_fwd;
   logic              w_fwd_eof;
   logic              w_inc_sent;
   logic              w_inc_drop;
   logic              w_inc_len;
   logic [WORD_W-1:0] r_data;
   logic              r_valid;
   logic              r_eof;
   logic              r_ovf;

   // tx_valid is held across ce=0 cycles, so only ce-qualified beats count
   assign w_acc      = ce & tx_valid;
   assign w_admit    = enable & gbe_link_up & ~gbe_tx_afull;
   // 1-based position of the current beat within the frame
   assign w_word_num = (r_state == ST_IDLE) ? LP_ONE : (r_wcnt + LP_ONE);
   assign w_last     = (w_word_num == LP_LAST);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: admission decided once per frame, mid-frame conditions ignored
   always_comb begin
      w_next = r_state;
      if (w_acc) begin
         case (r_state)
            ST_IDLE: begin
               if (tx_eof)       w_next = ST_IDLE;
               else if (!w_admit) w_next = ST_DROP;
               else if (w_last)  w_next = ST_DROP;
               else              w_next = ST_PASS;
            end
            ST_PASS: begin
               if (tx_eof)       w_next = ST_IDLE;
               else if (w_last)  w_next = ST_DROP;
               else              w_next = ST_PASS;
            end
            ST_DROP: begin
               if (tx_eof)       w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   // Outputs: forward/terminate decisions and counter strobes for the current beat
   always_comb begin
      w_fwd      = 1'b0;
      w_fwd_eof  = 1'b0;
      w_inc_sent = 1'b0;
      w_inc_drop = 1'b0;
      w_inc_len  = 1'b0;
      if (w_acc && (r_state != ST_DROP)) begin
         w_fwd      = (r_state == ST_PASS) | w_admit;
         w_inc_drop = (r_state == ST_IDLE) & ~w_admit;
         if (w_fwd) begin
            // Early eof, or a forced eof at the length limit, both mark a malformed frame
            w_fwd_eof  = tx_eof | w_last;
            w_inc_sent = tx_eof | w_last;
            w_inc_len  = tx_eof ? ~w_last : w_last;
         end
      end
   end

   // Word counter tracks beats already forwarded in the current frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wcnt <= '0;
      end else if (w_acc) begin
         r_wcnt <= (w_next == ST_PASS) ? w_word_num : '0;
      end
   end

   // Registered core interface; data holds while no word is forwarded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_eof   <= 1'b0;
      end else begin
         r_valid <= w_fwd;
         r_eof   <= w_fwd_eof;
         if (w_fwd) begin
            r_data <= tx_data;
         end
      end
   end

   // Overflow sticky: a new overflow pulse outranks a software clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
      end else if (gbe_tx_overflow) begin
         r_ovf <= 1'b1;
      end else if (clear) begin
         r_ovf <= 1'b0;
      end
   end

   gbe_stat_counter #(.W(CNT_W)) u_sent (
      .clk     (clk),
      .rst_n   (rst),
      .i_inc   (w_inc_sent),
      .i_clr   (clear),
      .o_count (pkt_sent)
   );

   gbe_stat_counter #(.W(CNT_W)) u_dropped (
      .clk     (clk),
      .rst_n   (rst),
      .i_inc   (w_inc_drop),
      .i_clr   (clear),
      .o_count (pkt_dropped)
   );

   gbe_stat_counter #(.W(ERR_W)) u_len_err (
      .clk     (clk),
      .rst_n   (rst),
      .i_inc   (w_inc_len),
      .i_clr   (clear),
      .o_count (len_err)
   );

   assign gbe_tx_data     = r_data;
   assign gbe_tx_valid    = r_valid;
   assign gbe_tx_eof      = r_eof;
   assign overflow_sticky = r_ovf;

endmodule

// File: tb/tb_gbe_tx_gate.sv
// tb/tb_gbe_tx_gate.sv - self-checking bench for gbe_tx_gate
module tb_gbe_tx_gate;

   localparam int FW = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic [63:0] tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_eof = 1'b0;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic        gbe_link_up = 1'b0;
   logic        gbe_tx_afull = 1'b0;
   logic        gbe_tx_overflow = 1'b0;
   logic [63:0] gbe_tx_data;
   logic        gbe_tx_valid;
   logic        gbe_tx_eof;
   logic [31:0] pkt_sent;
   logic [31:0] pkt_dropped;
   logic [15:0] len_err;
   logic        overflow_sticky;

   int checks = 0;
   int errors = 0;

   gbe_tx_gate #(.FRAME_WORDS(FW), .CNT_W(32), .ERR_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .ce              (ce),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_eof          (tx_eof),
      .enable          (enable),
      .clear           (clear),
      .gbe_link_up     (gbe_link_up),
      .gbe_tx_afull    (gbe_tx_afull),
      .gbe_tx_overflow (gbe_tx_overflow),
      .gbe_tx_data     (gbe_tx_data),
      .gbe_tx_valid    (gbe_tx_valid),
      .gbe_tx_eof      (gbe_tx_eof),
      .pkt_sent        (pkt_sent),
      .pkt_dropped     (pkt_dropped),
      .len_err         (len_err),
      .overflow_sticky (overflow_sticky)
   );

   always #5 clk = ~clk;

   // Reference model: frames as seen by the source, position counted from each frame start
   bit          m_in_frame;
   bit          m_keep;
   int          m_pos;
   int unsigned m_sent, m_drop, m_len;
   bit          m_ovf, m_valid, m_eof;
   logic [63:0] m_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_in_frame = 0; m_keep = 0; m_pos = 0;
      m_sent = 0; m_drop = 0; m_len = 0;
      m_ovf = 0; m_valid = 0; m_eof = 0; m_data = '0;
   endtask

   task automatic model_beat();
      m_valid = 0;
      m_eof   = 0;
      if (ce && tx_valid) begin
         if (!m_in_frame) begin
            m_keep     = enable && gbe_link_up && !gbe_tx_afull;
            m_pos      = 1;
            m_in_frame = 1;
            if (!m_keep) m_drop++;
         end else begin
            m_pos++;
         end
         if (m_keep && m_pos <= FW) begin
            m_valid = 1;
            m_data  = tx_data;
            m_eof   = tx_eof || (m_pos == FW);
            if (m_eof) m_sent++;
            if ((tx_eof && m_pos < FW) || (!tx_eof && m_pos == FW)) m_len++;
         end
         if (tx_eof) m_in_frame = 0;
      end
      if (clear) begin
         m_sent = 0; m_drop = 0; m_len = 0; m_ovf = 0;
      end
      if (gbe_tx_overflow) m_ovf = 1;
   endtask

   // One clock: model sees the same inputs the DUT samples, outputs compared 1 time unit later
   task automatic step();
      model_beat();
      @(posedge clk);
      #1;
      chk("valid", gbe_tx_valid, m_valid);
      chk("eof", gbe_tx_eof, m_eof);
      chk("data", gbe_tx_data, m_data);
      chk("sent", pkt_sent, m_sent);
      chk("dropped", pkt_dropped, m_drop);
      chk("len_err", len_err, m_len & 16'hFFFF);
      chk("ovf", overflow_sticky, m_ovf);
   endtask

   task automatic drive(input bit c, input bit v, input bit e, input bit en,
                        input bit lk, input bit af, input logic [63:0] d);
      ce = c; tx_valid = v; tx_eof = e; enable = en;
      gbe_link_up = lk; gbe_tx_afull = af; tx_data = d;
      clear = 0; gbe_tx_overflow = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk("rst_valid", gbe_tx_valid, 1'b0);
      chk("rst_eof", gbe_tx_eof, 1'b0);
      chk("rst_data", gbe_tx_data, 64'h0);
      chk("rst_sent", pkt_sent, 32'h0);
      chk("rst_len", len_err, 16'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      bit          ce, v, eof, en, lk, af;
      logic [63:0] d;
      bit          ev, eeof;
   } vec_t;

   function automatic vec_t mk(bit c, bit v, bit e, bit en, bit lk, bit af,
                               logic [63:0] d, bit ev, bit eeof);
      vec_t r;
      r.ce = c; r.v = v; r.eof = e; r.en = en; r.lk = lk; r.af = af;
      r.d = d; r.ev = ev; r.eeof = eeof;
      return r;
   endfunction

   vec_t tbl[$];

   initial begin
      int strobes;
      model_reset();

      // Directed frames with hand-derived per-beat expectations
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 64'h0, 0, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 1, i == 3, 1, 1, 0, 64'h10 + i, 1, i == 3));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 1, i == 3, 1, 1, i == 0, 64'h20 + i, 0, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 1, i == 3, 1, 1, 0, 64'h30 + i, 1, i == 3));
      for (int i = 0; i < 2; i++)
         tbl.push_back(mk(1, 1, i == 1, 1, 1, 0, 64'h40 + i, 1, i == 1));
      for (int i = 0; i < 6; i++)
         tbl.push_back(mk(1, 1, i == 5, 1, 1, 0, 64'h50 + i, i < 4, i == 3));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 64'h0, 0, 0));

      #2;
      chk("reset_valid", gbe_tx_valid, 1'b0);
      chk("reset_sent", pkt_sent, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[k]) begin
         drive(tbl[k].ce, tbl[k].v, tbl[k].eof, tbl[k].en, tbl[k].lk, tbl[k].af, tbl[k].d);
         step();
         chk("tbl_valid", gbe_tx_valid, tbl[k].ev);
         chk("tbl_eof", gbe_tx_eof, tbl[k].eeof);
         if (tbl[k].ev) chk("tbl_data", gbe_tx_data, tbl[k].d);
      end
      chk("tbl_sent", pkt_sent, 32'd4);
      chk("tbl_dropped", pkt_dropped, 32'd1);
      chk("tbl_len_err", len_err, 16'd2);

      // ce toggling with tx_valid held: one strobe per ce=1 beat
      do_reset();
      strobes = 0;
      for (int i = 0; i < 8; i++) begin
         drive(i % 2 == 0, 1, i == 6, 1, 1, 0, 64'h60 + i / 2);
         step();
         strobes += gbe_tx_valid;
      end
      chk("ce_strobes", strobes, 4);
      chk("ce_sent", pkt_sent, 32'd1);

      // enable removed mid-frame: frame completes, next frame dropped
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, i == 3, i == 0, 1, 0, 64'h70 + i);
         step();
      end
      chk("en_eof", gbe_tx_eof, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, i == 3, 0, 1, 0, 64'h80 + i);
         step();
      end
      chk("en_sent", pkt_sent, 32'd1);
      chk("en_dropped", pkt_dropped, 32'd1);

      // overflow sticky and clear priority
      drive(1, 0, 0, 1, 1, 0, 64'h0);
      gbe_tx_overflow = 1;
      step();
      chk("ovf_set", overflow_sticky, 1'b1);
      drive(1, 0, 0, 1, 1, 0, 64'h0);
      gbe_tx_overflow = 1; clear = 1;
      step();
      chk("ovf_set_wins", overflow_sticky, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, i == 3, 1, 1, 0, 64'h90 + i);
         clear = (i == 3);
         step();
      end
      chk("clr_sent", pkt_sent, 32'd0);
      chk("clr_ovf", overflow_sticky, 1'b0);

      // asynchronous reset mid-frame, then a fresh frame start
      drive(1, 1, 0, 1, 1, 0, 64'hA0);
      step();
      chk("pre_rst_valid", gbe_tx_valid, 1'b1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, i == 2, 1, 1, 0, 64'hB0 + i);
         step();
      end
      chk("post_rst_len", len_err, 16'd1);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(3) != 0, $urandom_range(9) < 7, $urandom_range(3) == 0,
               $urandom_range(9) != 0, $urandom_range(9) != 0, $urandom_range(4) == 0,
               {$urandom, $urandom});
         clear = ($urandom_range(49) == 0);
         gbe_tx_overflow = ($urandom_range(49) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gbe_tx_gate.md
Name: gbe_tx_gate

Overview:
- Sits directly downstream of the packetizer; consumes its tx_data/tx_valid/tx_eof word stream and drives the 10GbE core transmit interface.
- Admits or drops whole frames based on link state, core almost-full and a software enable, so the core never receives a partial frame.
- Enforces the fixed frame length and counts sent, dropped and malformed frames for software status registers.

Parameters:
- FRAME_WORDS, 1025, words per frame including the 64-bit payload-counter header; eof expected on word FRAME_WORDS.
- CNT_W, 32, width of the sent/dropped counters.
- ERR_W, 16, width of the length-error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- ce  in  1  clock enable; inputs are sampled only when ce=1
- tx_data  in  64  word from packetizer
- tx_valid  in  1  word valid from packetizer; held high across ce=0 cycles, so it is qualified by ce
- tx_eof  in  1  last word of frame, qualified with tx_valid
- enable  in  1  software transmit enable
- clear  in  1  synchronous pulse that zeroes the counters and overflow_sticky
- gbe_link_up  in  1  core link status
- gbe_tx_afull  in  1  core TX FIFO almost full
- gbe_tx_overflow  in  1  core TX FIFO overflow pulse
- gbe_tx_data  out  64  word to core
- gbe_tx_valid  out  1  single-cycle strobe per forwarded word
- gbe_tx_eof  out  1  end-of-frame, coincident with gbe_tx_valid
- pkt_sent  out  CNT_W  frames forwarded with gbe_tx_eof
- pkt_dropped  out  CNT_W  frames discarded at admission
- len_err  out  ERR_W  frames with early or missing eof
- overflow_sticky  out  1  set by gbe_tx_overflow

Behaviour:
- An accepted word (acc) is a cycle with ce=1 and tx_valid=1.
- All outputs are registered; latency from acc to gbe_tx_valid is 1 cycle.
- Reset values: all outputs 0, state IDLE, word counter 0.
- gbe_tx_valid and gbe_tx_eof are 0 in every cycle that does not follow a forwarded acc. gbe_tx_data holds its last value when invalid.
- States:
  - IDLE: on acc, admit if enable=1, gbe_link_up=1 and gbe_tx_afull=0.
    - Admitted: forward the word and go to PASS; word counter = 1.
    - Not admitted: go to DROP and increment pkt_dropped.
    - If tx_eof=1 on this first word, the frame is a single-word frame. Admitted: forward it with eof, increment pkt_sent and len_err (if FRAME_WORDS>1), stay in IDLE. Dropped: increment pkt_dropped only, stay in IDLE.
  - PASS: forward every acc and increment the word counter.
    - tx_eof before word FRAME_WORDS: forward with gbe_tx_eof=1, increment pkt_sent and len_err, go to IDLE.
    - tx_eof on word FRAME_WORDS: normal end; increment pkt_sent, go to IDLE.
    - Word FRAME_WORDS arrives without tx_eof: force gbe_tx_eof=1 on it, increment pkt_sent and len_err, go to DROP to discard the remainder. The remainder does not increment pkt_dropped.
  - DROP: discard each acc; on acc with tx_eof=1, go to IDLE.
- gbe_tx_afull, enable and link changes mid-frame are ignored. An admitted frame always completes.
- Counters wrap modulo 2^width.
- clear has priority over a same-cycle increment: counter = 0.
- overflow_sticky: set on gbe_tx_overflow=1, cleared by clear. Set wins over a simultaneous clear.
- ce=0: no state, counter or output-data change, except that gbe_tx_valid/gbe_tx_eof return to 0.
- Reset mid-frame: immediately returns to IDLE with outputs 0. The next acc is treated as a frame start, so a partial frame may be forwarded and counted in len_err.
- Word counter width: clog2(FRAME_WORDS+1) bits.

Decomposition:
- Shared package gbe_pkg holds:
  - the state enumeration (IDLE=0, PASS=1, DROP=2);
  - the default FRAME_WORDS constant, shared with the packetizer's words-per-frame;
  - the 64-bit word width constant.
- One natural sub-module, gbe_stat_counter: a parameterised-width counter with increment, synchronous clear with priority, and async active-low reset. It is instantiated three times.

Test Plan:
- FRAME_WORDS=4, enable=1, link=1, afull=0; 4 acc words 0x10..0x13 with eof on the 4th -> same words on gbe_tx_data 1 cycle later, gbe_tx_eof on 0x13, pkt_sent=1, len_err=0.
- afull=1 at first word of a 4-word frame, deasserting on word 2 -> no gbe_tx_valid for the frame, pkt_dropped=1. The following frame is forwarded, pkt_sent=1.
- eof on word 2 of a FRAME_WORDS=4 frame -> 2 words forwarded with eof on the 2nd, pkt_sent=1, len_err=1. A 6-word frame with no eof until word 6 -> 4 words forwarded with forced eof on word 4, words 5-6 discarded, len_err=2, pkt_dropped unchanged.
- tx_valid held high with ce toggling 1,0,1,0... -> exactly one gbe_tx_valid strobe per ce=1 cycle. A 4-word frame yields 4 strobes.
- enable dropped on word 2 of an admitted frame -> frame completes with eof. The next frame is dropped, pkt_dropped=1.
- gbe_tx_overflow pulse -> overflow_sticky=1. clear and an eof-completion in the same cycle -> pkt_sent=0. rst=0 asserted mid-frame -> outputs 0 with no clock edge needed.
